// File: rtl/alu_operand_fetch.sv
// Operand fetch for the per-container ALUs of one RMT stage. PHVs wait in an in-order
// buffer until their action word arrives. Each container then gets registered operands.

module alu_opnd_lane #(
  parameter int N    = 8,
  parameter int DW   = 48,
  parameter int AL   = 25,
  parameter int IW   = 3,
  parameter int LANE = 0
) (
  input  logic [N-1:0][DW-1:0] phv,
  input  logic [AL-1:0]        act,
  output logic [DW-1:0]        op1,
  output logic [DW-1:0]        op2
);
  localparam int IMM_W = AL - 4 - 2*IW;

  logic [3:0]       opcode;
  logic [IW-1:0]    idx1, idx2;
  logic [IMM_W-1:0] imm;
  logic [DW-1:0]    sel1, sel2;

  assign opcode = act[AL-1 -: 4];
  assign idx1   = act[AL-5 -: IW];
  assign idx2   = act[AL-5-IW -: IW];
  assign imm    = act[IMM_W-1:0];

  // An index past the last container reads as zero.
  assign sel1 = (int'(idx1) < N) ? phv[idx1] : '0;
  assign sel2 = (int'(idx2) < N) ? phv[idx2] : '0;

  always_comb begin
    op1 = phv[LANE];
    op2 = '0;
    case (opcode)
      4'b0001, 4'b0010, 4'b1001, 4'b1010: begin
        op1 = sel1;
        op2 = sel2;
      end
      4'b0011, 4'b0100: begin
        op1 = sel1;
        op2 = DW'(imm);
      end
      default: ;
    endcase
  end
endmodule

module alu_operand_fetch #(
  parameter int STAGE          = 0,
  parameter int NUM_CONTAINERS = 8,
  parameter int DATA_WIDTH     = 48,
  parameter int ACTION_LEN     = 25,
  parameter int IDX_WIDTH      = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CONTAINERS*DATA_WIDTH-1:0] phv_in,
  input  logic                                 phv_valid_in,
  input  logic [NUM_CONTAINERS*ACTION_LEN-1:0] action_in,
  input  logic                                 action_valid_in,
  output logic [NUM_CONTAINERS*DATA_WIDTH-1:0] operand_1_out,
  output logic [NUM_CONTAINERS*DATA_WIDTH-1:0] operand_2_out,
  output logic [NUM_CONTAINERS*ACTION_LEN-1:0] action_out,
  output logic [NUM_CONTAINERS-1:0]            action_valid_out,
  output logic [NUM_CONTAINERS*DATA_WIDTH-1:0] phv_out,
  output logic                                 phv_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
  output logic                                 overflow_err,
  output logic                                 orphan_err
);
  localparam int NC     = NUM_CONTAINERS;
  localparam int DW     = DATA_WIDTH;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int STAGES = 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STAGE < 0) begin : g_bad_param
    $error("alu_operand_fetch: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [NC*DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             empty, full;
  logic             pop, bypass, orphan, push, drop;
  logic [STAGES:0]  vld_pipe;

  logic [NC-1:0][DW-1:0]         pair_phv;
  logic [NC-1:0][ACTION_LEN-1:0] act;
  logic [NC-1:0][DW-1:0]         lane_op1, lane_op2;

  assign empty  = (count == '0);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign pop    = action_valid_in && !empty;
  assign bypass = action_valid_in && empty && phv_valid_in;
  assign orphan = action_valid_in && empty && !phv_valid_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push   = phv_valid_in && !bypass && (!full || pop);
  assign drop   = phv_valid_in && full && !pop;

  assign vld_pipe[0] = pop || bypass;
  assign pair_phv    = pop ? mem[rd_ptr] : phv_in;
  assign act         = action_in;

  for (genvar k = 0; k < NC; k++) begin : g_lane
    alu_opnd_lane #(
      .N(NC), .DW(DW), .AL(ACTION_LEN), .IW(IDX_WIDTH), .LANE(k)
    ) u_lane (
      .phv (pair_phv),
      .act (act[k]),
      .op1 (lane_op1[k]),
      .op2 (lane_op2[k])
    );
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= phv_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      orphan_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop)   overflow_err <= 1'b1;
      if (orphan) orphan_err   <= 1'b1;
    end
  end

  // Output stage: every bus is forced to zero outside pairing cycles.
  always_ff @(posedge clk) begin
    if (rst || !vld_pipe[0]) begin
      vld_pipe[STAGES:1] <= '0;
      operand_1_out      <= '0;
      operand_2_out      <= '0;
      action_out         <= '0;
      phv_out            <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      operand_1_out      <= lane_op1;
      operand_2_out      <= lane_op2;
      action_out         <= action_in;
      phv_out            <= pair_phv;
    end
  end

  assign phv_valid_out    = vld_pipe[STAGES];
  assign action_valid_out = {NC{vld_pipe[STAGES]}};
  assign fifo_count       = count;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: an 8-container instance plus a
// 6-container instance for index range handling.

module tb_alu_operand_fetch;
  localparam int DW = 48;
  localparam int AL = 25;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-container instance
  logic [7:0][DW-1:0] phv;
  logic [7:0][AL-1:0] act;
  logic               pv, av;
  logic [7:0][DW-1:0] op1, op2, phvo;
  logic [7:0][AL-1:0] acto;
  logic [7:0]         avo;
  logic               pvo;
  logic [2:0]         cnt;
  logic               ovf, orph;

  // 6-container instance
  logic [5:0][DW-1:0] phv6;
  logic [5:0][AL-1:0] act6;
  logic               pv6, av6;
  logic [5:0][DW-1:0] op1_6, op2_6, phvo6;
  logic [5:0][AL-1:0] acto6;
  logic [5:0]         avo6;
  logic               pvo6;
  logic [2:0]         cnt6;
  logic               ovf6, orph6;

  int errors = 0;
  int checks = 0;

  alu_operand_fetch #(.NUM_CONTAINERS(8)) dut (
    .clk(clk), .rst(rst), .phv_in(phv), .phv_valid_in(pv),
    .action_in(act), .action_valid_in(av),
    .operand_1_out(op1), .operand_2_out(op2), .action_out(acto),
    .action_valid_out(avo), .phv_out(phvo), .phv_valid_out(pvo),
    .fifo_count(cnt), .overflow_err(ovf), .orphan_err(orph)
  );

  alu_operand_fetch #(.NUM_CONTAINERS(6)) dut6 (
    .clk(clk), .rst(rst), .phv_in(phv6), .phv_valid_in(pv6),
    .action_in(act6), .action_valid_in(av6),
    .operand_1_out(op1_6), .operand_2_out(op2_6), .action_out(acto6),
    .action_valid_out(avo6), .phv_out(phvo6), .phv_valid_out(pvo6),
    .fifo_count(cnt6), .overflow_err(ovf6), .orphan_err(orph6)
  );

  function automatic logic [AL-1:0] mk(input logic [3:0] op, input logic [2:0] i1,
                                        input logic [2:0] i2, input logic [14:0] imm);
    return {op, i1, i2, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    phv = '0; act = '0; pv = 1'b0; av = 1'b0;
    phv6 = '0; act6 = '0; pv6 = 1'b0; av6 = 1'b0;
  endtask

  task automatic test_reset();
    phv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
    act = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pv = 1'b1; av = 1'b1; pv6 = 1'b1; av6 = 1'b1;
    rst = 1'b1;
    step(); step();
    checks++; if (pvo !== 1'b0) begin errors++; $display("FAIL reset_pvo: got %0b exp 0", pvo); end
    checks++; if (avo !== 8'h00) begin errors++; $display("FAIL reset_avo: got %0h exp 0", avo); end
    checks++; if (op1 !== '0 || op2 !== '0 || phvo !== '0 || acto !== '0) begin
      errors++; $display("FAIL reset_buses: op1=%0h op2=%0h phv=%0h act=%0h exp all 0", op1, op2, phvo, acto);
    end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", cnt); end
    checks++; if (ovf !== 1'b0 || orph !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ovf=%0b orph=%0b exp 0 0", ovf, orph);
    end
    rst = 1'b0;
    idle_in();
    step();
  endtask

  task automatic test_bypass();
    phv = '0; phv[0] = 48'd5; phv[1] = 48'd7;
    act = '0; act[0] = mk(4'b0001, 3'd0, 3'd1, 15'd0);
    pv = 1'b1; av = 1'b1;
    step();
    checks++; if (op1[0] !== 48'd5) begin errors++; $display("FAIL bypass_op1: got %0h exp 5", op1[0]); end
    checks++; if (op2[0] !== 48'd7) begin errors++; $display("FAIL bypass_op2: got %0h exp 7", op2[0]); end
    checks++; if (op1[1] !== 48'd7 || op2[1] !== 48'd0) begin
      errors++; $display("FAIL bypass_noop_lane1: got %0h/%0h exp 7/0", op1[1], op2[1]);
    end
    checks++; if (pvo !== 1'b1 || avo !== 8'hFF) begin
      errors++; $display("FAIL bypass_strobes: pvo=%0b avo=%0h exp 1 ff", pvo, avo);
    end
    checks++; if (phvo[1] !== 48'd7 || acto[0] !== mk(4'b0001, 3'd0, 3'd1, 15'd0)) begin
      errors++; $display("FAIL bypass_fwd: phv1=%0h act0=%0h", phvo[1], acto[0]);
    end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d exp 0", cnt); end
    idle_in();
    step();
    checks++; if (pvo !== 1'b0 || avo !== 8'h00 || op1 !== '0 || phvo !== '0) begin
      errors++; $display("FAIL bypass_one_cycle: pvo=%0b avo=%0h op1=%0h exp zeros", pvo, avo, op1);
    end
  endtask

  task automatic test_buffered();
    phv = '0; phv[2] = 48'h10; pv = 1'b1; step();
    phv = '0; phv[2] = 48'h20; pv = 1'b1; step();
    idle_in(); step(); step(); step();
    checks++; if (cnt !== 3'd2 || pvo !== 1'b0) begin
      errors++; $display("FAIL buf_fill: count=%0d pvo=%0b exp 2 0", cnt, pvo);
    end
    act = '0; act[2] = mk(4'b0011, 3'd2, 3'd0, 15'd3); av = 1'b1;
    step();
    checks++; if (op1[2] !== 48'h10 || op2[2] !== 48'd3) begin
      errors++; $display("FAIL buf_first: got %0h/%0h exp 10/3", op1[2], op2[2]);
    end
    checks++; if (pvo !== 1'b1 || phvo[2] !== 48'h10 || cnt !== 3'd1) begin
      errors++; $display("FAIL buf_first_meta: pvo=%0b phv2=%0h count=%0d exp 1 10 1", pvo, phvo[2], cnt);
    end
    step();
    checks++; if (op1[2] !== 48'h20 || op2[2] !== 48'd3 || pvo !== 1'b1) begin
      errors++; $display("FAIL buf_second: got %0h/%0h pvo=%0b exp 20/3 1", op1[2], op2[2], pvo);
    end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL buf_empty: got %0d exp 0", cnt); end
    idle_in();
    step();
  endtask

  task automatic test_noop_range();
    phv = '0; phv[5] = 48'hABCDEF; act = '0;
    pv = 1'b1; av = 1'b1;
    phv6 = '0; phv6[4] = 48'h44; phv6[5] = 48'h55;
    act6 = '0;
    act6[0] = mk(4'b0001, 3'd6, 3'd7, 15'd0);
    act6[1] = mk(4'b0011, 3'd7, 3'd0, 15'd9);
    act6[2] = mk(4'b0010, 3'd5, 3'd4, 15'd0);
    pv6 = 1'b1; av6 = 1'b1;
    step();
    checks++; if (op1[5] !== 48'hABCDEF || op2[5] !== 48'd0) begin
      errors++; $display("FAIL noop_c5: got %0h/%0h exp abcdef/0", op1[5], op2[5]);
    end
    checks++; if (op1_6[0] !== 48'd0 || op2_6[0] !== 48'd0) begin
      errors++; $display("FAIL range_both: got %0h/%0h exp 0/0", op1_6[0], op2_6[0]);
    end
    checks++; if (op1_6[1] !== 48'd0 || op2_6[1] !== 48'd9) begin
      errors++; $display("FAIL range_imm: got %0h/%0h exp 0/9", op1_6[1], op2_6[1]);
    end
    checks++; if (op1_6[2] !== 48'h55 || op2_6[2] !== 48'h44 || avo6 !== 6'h3F) begin
      errors++; $display("FAIL range_edge: got %0h/%0h avo=%0h exp 55/44 3f", op1_6[2], op2_6[2], avo6);
    end
    idle_in();
    step();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      phv = '0; phv[0] = 48'(i); pv = 1'b1;
      step();
      if (i == 4) begin
        checks++; if (cnt !== 3'd4 || ovf !== 1'b0) begin
          errors++; $display("FAIL ovf_full: count=%0d ovf=%0b exp 4 0", cnt, ovf);
        end
      end
    end
    checks++; if (cnt !== 3'd4 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_drop: count=%0d ovf=%0b exp 4 1", cnt, ovf);
    end
    phv = '0; phv[0] = 48'd6; pv = 1'b1;
    act = '0; act[0] = mk(4'b0001, 3'd0, 3'd0, 15'd0); av = 1'b1;
    step();
    checks++; if (cnt !== 3'd4 || op1[0] !== 48'd1 || op2[0] !== 48'd1 || pvo !== 1'b1) begin
      errors++; $display("FAIL ovf_pushpop: count=%0d op1=%0h op2=%0h pvo=%0b exp 4 1 1 1", cnt, op1[0], op2[0], pvo);
    end
    pv = 1'b0; phv = '0;
    step();
    checks++; if (op1[0] !== 48'd2) begin errors++; $display("FAIL ovf_drain0: got %0h exp 2", op1[0]); end
    step();
    checks++; if (op1[0] !== 48'd3) begin errors++; $display("FAIL ovf_drain1: got %0h exp 3", op1[0]); end
    step();
    checks++; if (op1[0] !== 48'd4) begin errors++; $display("FAIL ovf_drain2: got %0h exp 4", op1[0]); end
    step();
    checks++; if (op1[0] !== 48'd6 || cnt !== 3'd0) begin
      errors++; $display("FAIL ovf_drain3: got %0h count=%0d exp 6 0", op1[0], cnt);
    end
    idle_in();
    step();
  endtask

  task automatic test_orphan();
    act = '0; act[3] = mk(4'b0001, 3'd1, 3'd2, 15'd0); av = 1'b1;
    step();
    checks++; if (pvo !== 1'b0 || avo !== 8'h00 || orph !== 1'b1) begin
      errors++; $display("FAIL orphan: pvo=%0b avo=%0h orph=%0b exp 0 0 1", pvo, avo, orph);
    end
    idle_in();
    step(); step();
    checks++; if (orph !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %0b exp 1", orph); end
  endtask

  task automatic test_reset_mid();
    phv = '0; phv[0] = 48'h99; pv = 1'b1; step(); step();
    idle_in();
    rst = 1'b1; step();
    checks++; if (cnt !== 3'd0 || orph !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL midreset: count=%0d orph=%0b ovf=%0b exp 0 0 0", cnt, orph, ovf);
    end
    rst = 1'b0;
    act = '0; act[0] = mk(4'b0001, 3'd0, 3'd0, 15'd0); av = 1'b1;
    step();
    checks++; if (pvo !== 1'b0 || orph !== 1'b1 || op1[0] !== 48'd0) begin
      errors++; $display("FAIL midreset_discard: pvo=%0b orph=%0b op1=%0h exp 0 1 0", pvo, orph, op1[0]);
    end
    idle_in();
    step();
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    test_reset();
    test_bypass();
    test_buffered();
    test_noop_range();
    test_overflow();
    test_orphan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
